mbs_bus_responder: RTL and testbench
====================================

Name: mbs_bus_responder

Overview:
Shared-bus target for the MBSsoc system bus. It sits on the data/address/control bus opposite the CPU initiators and serves single-word read and write transactions to an internal word-addressed RAM window. A request/ready handshake with a configurable number of wait states lets the arbiter stall the CPUs through cpu_pause while the responder is busy. Accesses that are outside the window or not word-aligned complete with an error response.

Parameters:
DEPTH, 256, number of 32-bit words in the window; must be a power of 2 and at least 2.
BASE_ADDR, 32'h0000_1000, byte address of word 0; must be aligned to 4*DEPTH.
WAIT_CYCLES, 2, wait states inserted before the response; legal range 0..15.

Ports:
clk  input  1  system clock; all logic is rising-edge.
rst  input  1  asynchronous, active-high reset.
req  input  1  transaction request from the selected CPU.
we  input  1  1 = write, 0 = read; sampled together with req.
addr  input  32  byte address.
wdata  input  32  write data.
be  input  4  byte enables for writes; be[i] selects wdata[8i+7:8i].
ready  output  1  one-cycle completion strobe.
rdata  output  32  read data; valid only while ready=1.
err  output  1  decode error; valid only while ready=1.
busy  output  1  high while a transaction is in flight; feeds cpu_pause.

Behaviour:
- Reset: the state machine goes to IDLE and ready, err, busy and rdata are all 0. Asserting rst at any time aborts the current transaction immediately, and no write is committed. Reset does not clear RAM contents.
- States: IDLE, WAIT, RESP.
- IDLE: req is sampled at each rising edge.
  - When req=1, the block latches we, addr, wdata and be, and computes the decode.
  - The access is valid if addr[1:0]==0 and BASE_ADDR <= addr < BASE_ADDR+4*DEPTH.
  - The RAM index is addr[log2(DEPTH)+1:2].
  - Next state is WAIT if WAIT_CYCLES>0, otherwise RESP.
- WAIT: a counter is loaded with WAIT_CYCLES-1 on entry and decrements each cycle. When it reaches 0, the next state is RESP. Changes on req, we, addr, wdata and be during WAIT are ignored.
- RESP: lasts exactly one cycle, then the block returns to IDLE unconditionally. req is ignored in this cycle.
  - ready=1.
  - For a valid read: rdata = RAM[index] and err=0.
  - For a valid write: rdata=0 and err=0. The write commits at the clock edge that ends RESP, per byte under the latched be. be=4'b0000 completes normally as a no-op.
  - For an invalid access: err=1, rdata=0, and RAM is unchanged.
- Latency: if req is sampled at edge k, ready is high in the cycle after edge k+WAIT_CYCLES. This is 1+WAIT_CYCLES cycles.
- Back-to-back throughput: a new request can be accepted no earlier than the edge that ends RESP + 1, i.e. in the IDLE cycle. If req is still high in IDLE, the block starts a new transaction. The initiator must drop req in the cycle after ready unless it is issuing a further transaction.
- busy = (state != IDLE). It is registered-state derived and is 0 in the cycle req is first sampled.
- Outside RESP, ready, err and rdata are all 0.
- Address arithmetic uses unsigned 32-bit comparisons with no wrap. For example, BASE_ADDR-4 and BASE_ADDR+4*DEPTH are both invalid.

Test Plan:
1. Reset: assert rst for 1 cycle while in WAIT -> ready, err, busy and rdata are 0 immediately, without waiting for a clock edge; the block is back in IDLE.
2. Basic access (WAIT_CYCLES=2):
   - Write 32'hDEADBEEF to 0x1004 with be=4'hF -> ready is high for exactly 1 cycle, 3 cycles after the req sample edge; err=0; busy is high for 3 cycles.
   - Then read 0x1004 -> rdata=32'hDEADBEEF, err=0.
3. Byte enables: write 32'h11223344 with be=4'b0101 over 32'hDEADBEEF, then read -> 32'hDE22BE44. A write with be=0 leaves the value unchanged.
4. Decode errors:
   - Read 0x0FFC -> ready with err=1, rdata=0.
   - Read 0x1002 (misaligned) -> err=1, rdata=0.
   - Write 0x1400 -> err=1, RAM unchanged.
   - Read 0x13FC (last word) -> err=0.
5. Back-to-back: hold req high across ready with addr changed mid-WAIT -> the first transaction uses its latched address; the second is accepted in the IDLE cycle after RESP.
6. Reset during a write in WAIT -> no commit; a subsequent read returns the prior value. Repeat with WAIT_CYCLES=0 -> ready appears the cycle after the req sample.

Source files
------------

// File: rtl/mbs_bus_responder.sv
// rtl/mbs_bus_responder.sv - MBSsoc system-bus target serving a word-addressed RAM window
//
// Single-word read/write responder. A request sampled in IDLE is latched,
// decoded, held for WAIT_CYCLES wait states, and completed with a one-cycle
// ready strobe. Out-of-window or misaligned accesses complete with err=1.
//
// Ports:
//   clk    - system clock, rising-edge
//   rst    - asynchronous active-high reset (RAM contents are preserved)
//   req    - transaction request, sampled in IDLE
//   we     - 1 = write, 0 = read
//   addr   - byte address
//   wdata  - write data
//   be     - per-byte write enables
//   ready  - one-cycle completion strobe
//   rdata  - read data, non-zero only while ready=1 on a valid read
//   err    - decode error, valid only while ready=1
//   busy   - transaction in flight (drives cpu_pause)
module mbs_bus_responder #(
  parameter int          DEPTH       = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  // One past the last byte of the window, widened so the limit cannot wrap.
  localparam logic [32:0] END_ADDR  = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [3:0]    wait_cnt;
  logic          lat_we;
  logic          lat_valid;
  logic [AW-1:0] lat_idx;
  logic [31:0]   lat_wdata;
  logic [3:0]    lat_be;
  logic          addr_valid;

  logic [31:0] mem [DEPTH];

  assign addr_valid = (addr[1:0] == 2'b00) &&
                      (addr >= BASE_ADDR) &&
                      ({1'b0, addr} < END_ADDR);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req) begin
          state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request latch and wait-state counter; inputs are only looked at in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt  <= 4'd0;
      lat_we    <= 1'b0;
      lat_valid <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= 32'd0;
      lat_be    <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            wait_cnt  <= WAIT_LOAD;
            lat_we    <= we;
            lat_valid <= addr_valid;
            lat_idx   <= addr[AW+1:2];
            lat_wdata <= wdata;
            lat_be    <= be;
          end
        end
        S_WAIT: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // RAM write commits on the edge that ends RESP. The async reset forces
  // state to IDLE, so an aborted transaction can never reach this point;
  // the rst term also covers reset rising on the same edge.
  always_ff @(posedge clk) begin
    if (!rst && state == S_RESP && lat_we && lat_valid) begin
      for (int b = 0; b < 4; b++) begin
        if (lat_be[b]) begin
          mem[lat_idx][8*b +: 8] <= lat_wdata[8*b +: 8];
        end
      end
    end
  end

  // Outputs
  always_comb begin
    ready = 1'b0;
    err   = 1'b0;
    rdata = 32'd0;
    busy  = (state != S_IDLE);
    if (state == S_RESP) begin
      ready = 1'b1;
      if (!lat_valid) begin
        err = 1'b1;
      end else if (!lat_we) begin
        rdata = mem[lat_idx];
      end
    end
  end

endmodule

// File: tb/tb_mbs_bus_responder.sv
// tb/tb_mbs_bus_responder.sv - scoreboard bench for mbs_bus_responder (WAIT_CYCLES=2 and 0)
module tb_mbs_bus_responder;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  be    [2];
  logic        ready [2];
  logic [31:0] rdata [2];
  logic        err   [2];
  logic        busy  [2];

  mbs_bus_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .rst(rst), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
    .be(be[0]), .ready(ready[0]), .rdata(rdata[0]), .err(err[0]), .busy(busy[0])
  );

  mbs_bus_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
    .be(be[1]), .ready(ready[1]), .rdata(rdata[1]), .err(err[1]), .busy(busy[1])
  );

  always #5 clk = ~clk;

  typedef struct {
    int          unit;
    logic        err;
    logic [31:0] rdata;
    longint      k;    // cycle index of the sampling edge
    longint      cyc;  // cycle index in which ready is expected
  } exp_t;

  exp_t        q[$];
  logic [31:0] mm [2][DEPTH];
  longint      pcyc = 0;
  int          errors = 0;
  int          checks = 0;
  bit          bchk = 1'b1;

  always @(posedge clk) pcyc <= pcyc + 1;

  function automatic int wait_of(int u);
    return (u == 0) ? 2 : 0;
  endfunction

  function automatic bit addr_ok(logic [31:0] a);
    logic [63:0] a64;
    logic [63:0] lo;
    a64 = {32'd0, a};
    lo  = {32'd0, BASE};
    return (a % 4 == 0) && (a64 >= lo) && (a64 < lo + 4 * DEPTH);
  endfunction

  task automatic check(string name, int u, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s unit%0d: got %h expected %h", name, u, act, exp);
    end
  endtask

  // Reference model: applies writes to the model RAM immediately and queues
  // the response the DUT should give.
  task automatic model_push(int u, logic w, logic [31:0] a, logic [31:0] d,
                            logic [3:0] b, longint k);
    exp_t e;
    int   i;
    e.unit  = u;
    e.k     = k;
    e.cyc   = k + wait_of(u);
    e.err   = !addr_ok(a);
    e.rdata = 32'd0;
    if (addr_ok(a)) begin
      i = int'((a - BASE) / 4);
      if (w) begin
        for (int j = 0; j < 4; j++) begin
          if (b[j]) mm[u][i][8*j +: 8] = d[8*j +: 8];
        end
      end else begin
        e.rdata = mm[u][i];
      end
    end
    q.push_back(e);
  endtask

  task automatic scramble(int u);
    req[u]   = 1'b0;
    we[u]    = 1'($urandom);
    addr[u]  = $urandom;
    wdata[u] = $urandom;
    be[u]    = 4'($urandom);
  endtask

  task automatic issue(int u, logic w, logic [31:0] a, logic [31:0] d, logic [3:0] b);
    @(posedge clk); #2;
    req[u] = 1'b1; we[u] = w; addr[u] = a; wdata[u] = d; be[u] = b;
    model_push(u, w, a, d, b, pcyc + 1);
    @(posedge clk); #2;
    scramble(u);
    repeat (wait_of(u) + 1) @(posedge clk);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)       return BASE + 4 * $urandom_range(0, 15);
    else if (r == 7) return ($urandom_range(0, 1) == 0) ? BASE - 4 : BASE + 4 * DEPTH;
    else if (r == 8) return BASE + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
    else             return 32'h8000_0000 | $urandom;
  endfunction

  // Monitor: compares every DUT response against the scoreboard queue.
  exp_t mon_e;
  bit   mon_bexp;
  always @(negedge clk) begin
    if (!rst) begin
      for (int u = 0; u < 2; u++) begin
        mon_bexp = (q.size() > 0) && (q[0].unit == u) && (pcyc >= q[0].k) && (pcyc <= q[0].cyc);
        if (bchk) check("busy", u, 32'(busy[u]), 32'(mon_bexp));
        if (ready[u]) begin
          if (q.size() == 0 || q[0].unit != u) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready unit%0d: got ready=1 expected no response at cycle %0d", u, pcyc);
          end else begin
            mon_e = q.pop_front();
            check("ready_cycle", u, 32'(pcyc), 32'(mon_e.cyc));
            check("err", u, 32'(err[u]), 32'(mon_e.err));
            check("rdata", u, rdata[u], mon_e.rdata);
          end
        end else begin
          check("idle_err", u, 32'(err[u]), 32'd0);
          check("idle_rdata", u, rdata[u], 32'd0);
          if (q.size() > 0 && q[0].unit == u && pcyc > q[0].cyc) begin
            mon_e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_ready unit%0d: got no ready expected ready at cycle %0d", u, mon_e.cyc);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: got no finish expected finish within budget");
    $fatal(1, "timeout");
  end

  initial begin
    for (int u = 0; u < 2; u++) begin
      req[u] = 1'b0; we[u] = 1'b0; addr[u] = 32'd0; wdata[u] = 32'd0; be[u] = 4'd0;
    end
    repeat (2) @(posedge clk);
    #2;
    for (int u = 0; u < 2; u++) begin
      check("rst_ready", u, 32'(ready[u]), 32'd0);
      check("rst_err", u, 32'(err[u]), 32'd0);
      check("rst_busy", u, 32'(busy[u]), 32'd0);
      check("rst_rdata", u, rdata[u], 32'd0);
    end
    rst = 1'b0;

    // Give every word the random phase may read a known value.
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 16; i++) issue(u, 1'b1, BASE + 4 * i, $urandom, 4'hF);
      issue(u, 1'b1, BASE + 4 * 255, $urandom, 4'hF);
    end

    // Basic access, byte enables, decode errors (WAIT_CYCLES=2)
    issue(0, 1'b1, 32'h1004, 32'hDEADBEEF, 4'hF);
    issue(0, 1'b0, 32'h1004, 32'h0, 4'h0);
    issue(0, 1'b1, 32'h1004, 32'h11223344, 4'b0101);
    issue(0, 1'b0, 32'h1004, 32'h0, 4'h0);
    issue(0, 1'b1, 32'h1004, 32'hFFFFFFFF, 4'b0000);
    issue(0, 1'b0, 32'h1004, 32'h0, 4'h0);
    issue(0, 1'b0, 32'h0FFC, 32'h0, 4'h0);
    issue(0, 1'b0, 32'h1002, 32'h0, 4'h0);
    issue(0, 1'b1, 32'h1400, 32'h5A5A5A5A, 4'hF);
    issue(0, 1'b0, 32'h1000, 32'h0, 4'h0);
    issue(0, 1'b0, 32'h13FC, 32'h0, 4'h0);

    // Back-to-back: req held across ready, inputs changed mid-WAIT
    begin
      longint ka;
      @(posedge clk); #2;
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = BASE + 8; wdata[0] = 32'hA5A51234; be[0] = 4'hF;
      model_push(0, 1'b1, BASE + 8, 32'hA5A51234, 4'hF, pcyc + 1);
      @(posedge clk); #2;
      ka = pcyc;
      we[0] = 1'b0; addr[0] = BASE + 12; wdata[0] = $urandom; be[0] = 4'($urandom);
      model_push(0, 1'b0, BASE + 12, 32'h0, 4'h0, ka + wait_of(0) + 2);
      repeat (wait_of(0) + 2) @(posedge clk);
      #2;
      scramble(0);
      repeat (wait_of(0) + 1) @(posedge clk);
    end
    issue(0, 1'b0, BASE + 8, 32'h0, 4'h0);

    // Reset while a write sits in WAIT: nothing committed
    @(posedge clk); #2;
    bchk = 1'b0;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h1004; wdata[0] = 32'hCAFEF00D; be[0] = 4'hF;
    @(posedge clk); #2;
    scramble(0);
    check("busy_in_wait", 0, 32'(busy[0]), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_ready", 0, 32'(ready[0]), 32'd0);
    check("abort_err", 0, 32'(err[0]), 32'd0);
    check("abort_busy", 0, 32'(busy[0]), 32'd0);
    check("abort_rdata", 0, rdata[0], 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    bchk = 1'b1;
    issue(0, 1'b0, 32'h1004, 32'h0, 4'h0);

    // Zero wait states
    issue(1, 1'b1, 32'h1004, 32'hDEADBEEF, 4'hF);
    issue(1, 1'b0, 32'h1004, 32'h0, 4'h0);
    issue(1, 1'b0, 32'h0FFC, 32'h0, 4'h0);
    issue(1, 1'b0, 32'h13FC, 32'h0, 4'h0);

    // Reset during RESP on the zero-wait instance: the write must not land
    @(posedge clk); #2;
    bchk = 1'b0;
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h1004; wdata[1] = 32'h0BADCAFE; be[1] = 4'hF;
    @(posedge clk); #2;
    scramble(1);
    rst = 1'b1;
    #1;
    check("abort_resp_ready", 1, 32'(ready[1]), 32'd0);
    check("abort_resp_busy", 1, 32'(busy[1]), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    bchk = 1'b1;
    issue(1, 1'b0, 32'h1004, 32'h0, 4'h0);

    // Randomized traffic
    for (int u = 0; u < 2; u++) begin
      for (int n = 0; n < 60; n++) begin
        issue(u, 1'($urandom), rand_addr(), $urandom, 4'($urandom));
      end
    end

    repeat (5) @(posedge clk);
    #2;
    check("queue_drained", 0, 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
